peripheral_ahb3_sram_slave: RTL and testbench
=============================================

PERIPHERAL_AHB3_SRAM_SLAVE -- requirements
Module: peripheral_ahb3_sram_slave

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 64, data width (64 only).
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of 64-bit memory words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, wait cycles per accepted transfer (0-15).
REQ-005 SHALL have ports:
  HCLK  in  1  clock; one clock, all logic on rising edge
  HRESET  in  1  reset, synchronous, active-high
  HSEL  in  1  slave select
  HADDR  in  HADDR_SIZE  address
  HWDATA  in  HDATA_SIZE  write data (data phase)
  HRDATA  out  HDATA_SIZE  read data
  HWRITE  in  1  1=write
  HSIZE  in  3  BYTE=000, HWORD=001, WORD=010, DWORD=011, QWORD=100
  HBURST  in  3  burst type (accepted, not checked)
  HPROT  in  4  protection (ignored)
  HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
  HMASTLOCK  in  1  lock (ignored)
  HREADY  in  1  bus ready (previous data phase complete)
  HREADYOUT  out  1  slave ready
  HRESP  out  1  0=OKAY, 1=ERROR

Function
REQ-006 SHALL accept an address phase when HSEL=1, HREADY=1, HTRANS in {NONSEQ,SEQ}; capture HADDR, HWRITE, HSIZE into data-phase registers.
REQ-007 SHALL treat IDLE/BUSY or HSEL=0 as no transfer: next data phase HREADYOUT=1, HRESP=0, no memory access.
REQ-008 SHALL classify accepted transfer as error if HSIZE>DWORD, HADDR misaligned for HSIZE, or HADDR[HADDR_SIZE-1:3]>=MEM_DEPTH.
REQ-009 SHALL implement FSM states IDLE, WAIT, DATA, ERR1, ERR2.
REQ-010 Transitions: accepted error -> ERR1; accepted valid with WAIT_STATES>0 -> WAIT; accepted valid with WAIT_STATES=0 -> DATA; no accepted transfer -> IDLE.
REQ-011 WAIT: HREADYOUT=0, HRESP=0; wait counter loaded with WAIT_STATES on acceptance, decremented each cycle; at 1 -> DATA.
REQ-012 DATA: HREADYOUT=1, HRESP=0; next state per REQ-010 from current address phase (back-to-back pipelining, no bubble).
REQ-013 ERR1: HREADYOUT=0, HRESP=1; always -> ERR2.
REQ-014 ERR2: HREADYOUT=1, HRESP=1; next state per REQ-010 from current address phase.
REQ-015 Address phases presented while HREADYOUT=0 SHALL NOT be accepted (HREADY low).
REQ-016 Write SHALL update memory at end of DATA cycle with HWDATA under byte enables: BYTE 1 lane, HWORD 2, WORD 4, DWORD 8, lane offset from captured HADDR[2:0].
REQ-017 Read SHALL drive HRDATA = mem[captured word address] during DATA (full 64-bit word, unmasked); HRDATA=0 in all other states and for writes.
REQ-018 Read immediately following write to same word SHALL return newly written data (write completes before next data phase).
REQ-019 ERR1/ERR2 SHALL NOT modify memory.
REQ-020 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-021 On HRESET=1 at rising edge: state=IDLE, wait counter=0, data-phase registers cleared; HREADYOUT=1, HRESP=0, HRDATA=0 next cycle.
REQ-022 Reset asserted mid-WAIT/ERR1 SHALL abort the transfer with no memory write; first address phase after reset release accepted normally.

Verification
REQ-023 WAIT_STATES=0: NONSEQ write DWORD 0x0000_0010 data 0x1122_3344_5566_7788, then NONSEQ read same -> HRDATA=0x1122_3344_5566_7788, HREADYOUT=1 every cycle, HRESP=0.
REQ-024 BYTE write 0xAB to 0x0000_0013 over word 0 -> read DWORD 0x10 returns 0x1122_3344_AB66_7788 (lane 3 only changed).
REQ-025 WAIT_STATES=2: single read -> HREADYOUT low exactly 2 cycles, data valid on 3rd data-phase cycle; INCR4 SEQ burst -> 12 total data-phase cycles.
REQ-026 Errors: QWORD transfer, WORD at 0x0000_0002, DWORD at MEM_DEPTH*8 -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; memory unchanged on readback.
REQ-027 BUSY inserted mid INCR burst and HSEL=0 cycles -> OKAY zero-wait, no access; HRESET pulse during WAIT of a write -> memory unchanged, outputs at reset values next cycle.

Source files
------------

// File: rtl/peripheral_ahb3_sram_slave.sv
// AHB3-Lite SRAM slave over 64-bit words; accepted transfers complete after WAIT_STATES extra cycles (zero = single cycle).
// Stalls the bus with HREADYOUT low during wait and ERROR first cycles; HRDATA reads the array combinationally in DATA.
module peripheral_ahb3_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 64,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int                    AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]            LP_WAIT  = 4'(WAIT_STATES);
  localparam logic [HADDR_SIZE-4:0] LP_DEPTH = (HADDR_SIZE-3)'(MEM_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                r_state;
  logic [3:0]            r_wait_cnt;
  logic [AW+2:0]         r_addr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_err;
  logic [7:0]            w_be;
  logic [AW-1:0]         w_word;
  logic                  w_unused;

  assign w_accept = HSEL & HREADY & HTRANS[1];
  assign w_word   = r_addr[AW+2:3];
  assign w_unused = ^{HBURST, HPROT, HMASTLOCK};

  always_comb begin
    w_misalign = 1'b0;
    case (HSIZE)
      3'b001:  w_misalign = HADDR[0];
      3'b010:  w_misalign = |HADDR[1:0];
      3'b011:  w_misalign = |HADDR[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_err = (HSIZE > 3'd3) | w_misalign | (HADDR[HADDR_SIZE-1:3] >= LP_DEPTH);

  always_comb begin
    case (r_size)
      3'b000:  w_be = 8'h01 << r_addr[2:0];
      3'b001:  w_be = 8'h03 << r_addr[2:0];
      3'b010:  w_be = 8'h0F << r_addr[2:0];
      default: w_be = 8'hFF;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 4'd0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= 3'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          r_wait_cnt <= (r_wait_cnt <= 4'd1) ? 4'd0 : r_wait_cnt - 4'd1;
          if (r_wait_cnt <= 4'd1) begin
            r_state     <= ST_DATA;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all sample the address phase on the bus now
          if (w_accept) begin
            r_addr  <= HADDR[AW+2:0];
            r_write <= HWRITE;
            r_size  <= HSIZE;
            if (w_err) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (LP_WAIT != 4'd0) begin
              r_state     <= ST_WAIT;
              r_wait_cnt  <= LP_WAIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end else begin
              r_state     <= ST_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage is deliberately outside reset so contents survive HRESET
  always_ff @(posedge HCLK) begin
    if (!HRESET && r_state == ST_DATA && r_write) begin
      for (int i = 0; i < 8; i++) begin
        if (w_be[i]) r_mem[w_word][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA    = (r_state == ST_DATA && !r_write) ? r_mem[w_word] : '0;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule

// File: tb/tb_peripheral_ahb3_sram_slave.sv
// Bench for peripheral_ahb3_sram_slave: zero-wait and two-wait-state instances driven by one pipelined master.
module tb_peripheral_ahb3_sram_slave;

  typedef struct {
    int          id;
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_D = 3'd3, SZ_Q = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_hsel;
  logic [31:0] m_haddr;
  logic [63:0] m_hwdata;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [2:0]  m_hburst;
  logic [3:0]  m_hprot;
  logic [1:0]  m_htrans;
  logic        m_hmastlock;
  int          m_dut;

  logic        ready0, ready2, resp0, resp2;
  logic [63:0] rdata0, rdata2;
  logic        bus_ready, bus_resp;
  logic [63:0] bus_rdata;

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t tab[$];

  always #5 clk = ~clk;

  assign bus_ready = (m_dut == 2) ? ready2 : ready0;
  assign bus_resp  = (m_dut == 2) ? resp2  : resp0;
  assign bus_rdata = (m_dut == 2) ? rdata2 : rdata0;

  peripheral_ahb3_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(m_hsel && (m_dut == 0)), .HADDR(m_haddr),
    .HWDATA(m_hwdata), .HRDATA(rdata0), .HWRITE(m_hwrite), .HSIZE(m_hsize),
    .HBURST(m_hburst), .HPROT(m_hprot), .HTRANS(m_htrans), .HMASTLOCK(m_hmastlock),
    .HREADY(ready0), .HREADYOUT(ready0), .HRESP(resp0)
  );

  peripheral_ahb3_sram_slave #(.WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESET(rst), .HSEL(m_hsel && (m_dut == 2)), .HADDR(m_haddr),
    .HWDATA(m_hwdata), .HRDATA(rdata2), .HWRITE(m_hwrite), .HSIZE(m_hsize),
    .HBURST(m_hburst), .HPROT(m_hprot), .HTRANS(m_htrans), .HMASTLOCK(m_hmastlock),
    .HREADY(ready2), .HREADYOUT(ready2), .HRESP(resp2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                              input logic [2:0] sz, input logic [31:0] a,
                              input logic [63:0] wd, input logic [63:0] rd, input logic er);
    vec_t v;
    v.id = tab.size(); v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz;
    v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er;
    return v;
  endfunction

  function automatic int exp_waits(input vec_t e, input int dut);
    if (!(e.sel && e.trans[1])) return 0;
    if (e.err) return 1;
    return (dut == 2) ? 2 : 0;
  endfunction

  task automatic drive(input vec_t v);
    m_hsel = v.sel; m_htrans = v.trans; m_hwrite = v.wr;
    m_hsize = v.size; m_haddr = v.addr; m_hburst = 3'b001;
  endtask

  task automatic drive_idle();
    m_hsel = 1'b0; m_htrans = T_IDLE; m_hwrite = 1'b0;
    m_hsize = SZ_B; m_haddr = 32'h0; m_hburst = 3'b000;
  endtask

  // Pipelined master: address of row idx while the queue front is in its data phase
  task automatic run_table(input int dut, input int lo, input int hi, output int cyc);
    int   idx   = lo;
    int   waits = 0;
    int   guard = 0;
    vec_t cur;
    m_dut = dut;
    cyc   = 0;
    while ((idx <= hi || sb.size() != 0) && guard < 500) begin
      guard++;
      if (idx <= hi) drive(tab[idx]); else drive_idle();
      @(negedge clk);
      if (sb.size() != 0) begin
        cur = sb[0];
        if (!bus_ready) begin
          waits++;
          chk($sformatf("wait_hresp r%0d", cur.id), 64'(bus_resp), 64'(cur.err));
          chk($sformatf("wait_hrdata r%0d", cur.id), bus_rdata, 64'h0);
        end else begin
          chk($sformatf("waits r%0d", cur.id), 64'(waits), 64'(exp_waits(cur, dut)));
          chk($sformatf("hresp r%0d", cur.id), 64'(bus_resp), 64'(cur.err));
          chk($sformatf("hrdata r%0d", cur.id), bus_rdata, cur.rdata);
          if (cur.sel && cur.trans[1]) cyc += waits + 1;
          void'(sb.pop_front());
          waits = 0;
        end
      end
      if (bus_ready && idx <= hi) begin
        sb.push_back(tab[idx]);
        idx++;
      end
      @(posedge clk); #1;
      if (sb.size() != 0) m_hwdata = sb[0].wdata;
    end
    if (guard >= 500) begin
      total++;
      bad++;
      $display("FAIL timeout rows %0d..%0d: pending=%0d want 0", lo, hi, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int c;
    // ws0: basic, byte lanes, read-after-write (rows 0-10)
    tab.push_back(mk(1, T_NS, 1, SZ_D, 32'h10, 64'h1122334455667788, 64'h0, 0));
    tab.push_back(mk(1, T_NS, 0, SZ_D, 32'h10, 64'h0, 64'h1122334455667788, 0));
    tab.push_back(mk(1, T_NS, 1, SZ_B, 32'h13, 64'hFFFFFFFF_ABFFFFFF, 64'h0, 0));
    tab.push_back(mk(1, T_NS, 0, SZ_D, 32'h10, 64'h0, 64'h11223344_AB667788, 0));
    tab.push_back(mk(1, T_NS, 1, SZ_H, 32'h16, 64'hBEEF5555_55555555, 64'h0, 0));
    tab.push_back(mk(1, T_NS, 1, SZ_D, 32'h18, 64'h01234567_89ABCDEF, 64'h0, 0));
    tab.push_back(mk(1, T_NS, 1, SZ_W, 32'h1C, 64'hDEADBEEF_77777777, 64'h0, 0));
    tab.push_back(mk(1, T_NS, 0, SZ_D, 32'h10, 64'h0, 64'hBEEF3344_AB667788, 0));
    tab.push_back(mk(1, T_NS, 0, SZ_D, 32'h18, 64'h0, 64'hDEADBEEF_89ABCDEF, 0));
    tab.push_back(mk(1, T_NS, 0, SZ_W, 32'h14, 64'h0, 64'hBEEF3344_AB667788, 0));
    tab.push_back(mk(1, T_NS, 0, SZ_B, 32'h11, 64'h0, 64'hBEEF3344_AB667788, 0));
    // ws0: error responses leave memory alone (rows 11-17)
    tab.push_back(mk(1, T_NS, 1, SZ_D, 32'h00, 64'hA5A5A5A5_A5A5A5A5, 64'h0, 0));
    tab.push_back(mk(1, T_NS, 1, SZ_Q, 32'h10, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1));
    tab.push_back(mk(1, T_NS, 1, SZ_W, 32'h02, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1));
    tab.push_back(mk(1, T_NS, 1, SZ_D, 32'h800, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1));
    tab.push_back(mk(1, T_NS, 1, SZ_H, 32'h11, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1));
    tab.push_back(mk(1, T_NS, 0, SZ_D, 32'h00, 64'h0, 64'hA5A5A5A5_A5A5A5A5, 0));
    tab.push_back(mk(1, T_NS, 0, SZ_D, 32'h10, 64'h0, 64'hBEEF3344_AB667788, 0));
    // ws0: BUSY and deselected cycles inside a burst (rows 18-29)
    tab.push_back(mk(1, T_NS,   1, SZ_D, 32'h40, 64'h11111111_11111111, 64'h0, 0));
    tab.push_back(mk(1, T_NS,   1, SZ_D, 32'h48, 64'h22222222_22222222, 64'h0, 0));
    tab.push_back(mk(1, T_NS,   1, SZ_D, 32'h20, 64'h33333333_33333333, 64'h0, 0));
    tab.push_back(mk(1, T_BUSY, 1, SZ_D, 32'h40, 64'h99999999_99999999, 64'h0, 0));
    tab.push_back(mk(1, T_SEQ,  1, SZ_D, 32'h28, 64'h44444444_44444444, 64'h0, 0));
    tab.push_back(mk(0, T_NS,   1, SZ_D, 32'h48, 64'h99999999_99999999, 64'h0, 0));
    tab.push_back(mk(1, T_SEQ,  1, SZ_D, 32'h30, 64'h55555555_55555555, 64'h0, 0));
    tab.push_back(mk(1, T_NS,   0, SZ_D, 32'h40, 64'h0, 64'h11111111_11111111, 0));
    tab.push_back(mk(1, T_NS,   0, SZ_D, 32'h48, 64'h0, 64'h22222222_22222222, 0));
    tab.push_back(mk(1, T_NS,   0, SZ_D, 32'h20, 64'h0, 64'h33333333_33333333, 0));
    tab.push_back(mk(1, T_SEQ,  0, SZ_D, 32'h28, 64'h0, 64'h44444444_44444444, 0));
    tab.push_back(mk(1, T_SEQ,  0, SZ_D, 32'h30, 64'h0, 64'h55555555_55555555, 0));
    // ws2: single, INCR4 write and read bursts, error (rows 30-41)
    tab.push_back(mk(1, T_NS,  1, SZ_D, 32'h10, 64'h0F0E0D0C_0B0A0908, 64'h0, 0));
    tab.push_back(mk(1, T_NS,  0, SZ_D, 32'h10, 64'h0, 64'h0F0E0D0C_0B0A0908, 0));
    tab.push_back(mk(1, T_NS,  1, SZ_D, 32'h20, 64'hA0A0A0A0_A0A0A0A0, 64'h0, 0));
    tab.push_back(mk(1, T_SEQ, 1, SZ_D, 32'h28, 64'hA1A1A1A1_A1A1A1A1, 64'h0, 0));
    tab.push_back(mk(1, T_SEQ, 1, SZ_D, 32'h30, 64'hA2A2A2A2_A2A2A2A2, 64'h0, 0));
    tab.push_back(mk(1, T_SEQ, 1, SZ_D, 32'h38, 64'hA3A3A3A3_A3A3A3A3, 64'h0, 0));
    tab.push_back(mk(1, T_NS,  0, SZ_D, 32'h20, 64'h0, 64'hA0A0A0A0_A0A0A0A0, 0));
    tab.push_back(mk(1, T_SEQ, 0, SZ_D, 32'h28, 64'h0, 64'hA1A1A1A1_A1A1A1A1, 0));
    tab.push_back(mk(1, T_SEQ, 0, SZ_D, 32'h30, 64'h0, 64'hA2A2A2A2_A2A2A2A2, 0));
    tab.push_back(mk(1, T_SEQ, 0, SZ_D, 32'h38, 64'h0, 64'hA3A3A3A3_A3A3A3A3, 0));
    tab.push_back(mk(1, T_NS,  0, SZ_Q, 32'h10, 64'h0, 64'h0, 1));
    tab.push_back(mk(1, T_NS,  0, SZ_D, 32'h10, 64'h0, 64'h0F0E0D0C_0B0A0908, 0));
    // after reset pulse: both memories keep contents (rows 42-43)
    tab.push_back(mk(1, T_NS,  0, SZ_D, 32'h10, 64'h0, 64'h0F0E0D0C_0B0A0908, 0));
    tab.push_back(mk(1, T_NS,  0, SZ_D, 32'h10, 64'h0, 64'hBEEF3344_AB667788, 0));

    m_dut = 0; m_hwdata = 64'h0; m_hprot = 4'h0; m_hmastlock = 1'b0;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 64'(ready0), 64'h1);
    chk("rst_resp0",  64'(resp0),  64'h0);
    chk("rst_rdata0", rdata0,      64'h0);
    chk("rst_ready2", 64'(ready2), 64'h1);
    chk("rst_resp2",  64'(resp2),  64'h0);
    chk("rst_rdata2", rdata2,      64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_table(0, 0, 29, c);
    run_table(2, 30, 31, c);
    run_table(2, 32, 35, c);
    chk("incr4_wr_cycles", 64'(c), 64'd12);
    run_table(2, 36, 39, c);
    chk("incr4_rd_cycles", 64'(c), 64'd12);
    run_table(2, 40, 41, c);

    // Reset pulse while a ws2 write sits in WAIT must abort it
    m_dut = 2;
    drive(mk(1, T_NS, 1, SZ_D, 32'h10, 64'h0, 64'h0, 0));
    @(negedge clk);
    chk("abort_pre_ready", 64'(bus_ready), 64'h1);
    @(posedge clk); #1;
    drive_idle();
    m_hwdata = 64'hFFFF0000_FFFF0000;
    @(negedge clk);
    chk("abort_in_wait", 64'(bus_ready), 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(bus_ready), 64'h1);
    chk("abort_resp",  64'(bus_resp),  64'h0);
    chk("abort_rdata", bus_rdata,      64'h0);
    @(posedge clk); #1;

    run_table(2, 42, 42, c);
    run_table(0, 43, 43, c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
